// File: rtl/adsr_env.sv
// adsr_env
// ADSR envelope generator producing a 7-bit level (0..127).
// The level moves one step at a time. Each step takes a programmable
// number of rate ticks, and the count depends on the current phase.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   tick           one-cycle envelope-rate strobe that advances the period counter
//   gate           note on (1) / note off (0), level-sensitive
//   attack_time    ticks per +1 step while attacking
//   decay_time     ticks per -1 step while decaying
//   sustain_level  level held while the note is sustained
//   release_time   ticks per -1 step while releasing
//   env_out        current envelope level (registered)
//   env_strobe     one-cycle pulse in the cycle after env_out changes
//   state          IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//   active         high whenever the envelope is not idle
module adsr_env #(
  parameter int TIME_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              gate,
  input  logic [TIME_W-1:0] attack_time,
  input  logic [TIME_W-1:0] decay_time,
  input  logic [6:0]        sustain_level,
  input  logic [TIME_W-1:0] release_time,
  output logic [6:0]        env_out,
  output logic              env_strobe,
  output logic [2:0]        state,
  output logic              active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t            st;
  logic              gate_d;
  logic [TIME_W-1:0] counter;
  logic [TIME_W-1:0] period_sel;
  logic [TIME_W-1:0] last_count;
  logic [6:0]        env_prev;
  logic              rise;
  logic              fall;
  logic              step;

  // Gate edges come from the live gate input and the level registered on the
  // previous edge. Because gate_d clears on reset, a gate held high through
  // reset release counts as a fresh note-on.
  assign rise = gate & ~gate_d;
  assign fall = ~gate & gate_d;

  // Pick the step period for the current phase. A period of zero behaves
  // like one, so the final count index is period-1, clamped at zero.
  always_comb begin
    period_sel = '0;
    case (st)
      ATTACK:  period_sel = attack_time;
      DECAY:   period_sel = decay_time;
      RELEASE: period_sel = release_time;
      default: period_sel = '0;
    endcase
  end

  assign last_count = (period_sel == '0) ? '0 : period_sel - TIME_W'(1);

  // The compare uses >= so that shortening the period mid-phase steps on the
  // next tick instead of waiting for the counter to wrap.
  assign step = tick && (counter >= last_count);

  // Main envelope state machine. Gate edges override any level step in the
  // same cycle. Within a phase, the counter clears on a step, advances on a
  // tick, and holds otherwise. A phase whose end level is reached by a step
  // changes state on that same edge, so the level and the state agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      env_out  <= '0;
      env_prev <= '0;
      counter  <= '0;
      gate_d   <= 1'b0;
    end else begin
      gate_d   <= gate;
      env_prev <= env_out;
      if (rise) begin
        st      <= ATTACK;
        counter <= '0;
      end else if (fall && (st == ATTACK || st == DECAY || st == SUSTAIN)) begin
        st      <= RELEASE;
        counter <= '0;
      end else begin
        case (st)
          ATTACK: begin
            if (env_out == 7'd127) begin
              st      <= DECAY;
              counter <= '0;
            end else if (step) begin
              env_out <= env_out + 7'd1;
              counter <= '0;
              if (env_out == 7'd126) st <= DECAY;
            end else if (tick) begin
              counter <= counter + TIME_W'(1);
            end
          end
          DECAY: begin
            if (env_out <= sustain_level) begin
              st      <= SUSTAIN;
              env_out <= sustain_level;
              counter <= '0;
            end else if (step) begin
              env_out <= env_out - 7'd1;
              counter <= '0;
              if ((env_out - 7'd1) <= sustain_level) st <= SUSTAIN;
            end else if (tick) begin
              counter <= counter + TIME_W'(1);
            end
          end
          SUSTAIN: begin
            env_out <= sustain_level;
            counter <= '0;
          end
          RELEASE: begin
            if (env_out == 7'd0) begin
              st      <= IDLE;
              counter <= '0;
            end else if (step) begin
              env_out <= env_out - 7'd1;
              counter <= '0;
              if (env_out == 7'd1) st <= IDLE;
            end else if (tick) begin
              counter <= counter + TIME_W'(1);
            end
          end
          default: begin
            st      <= IDLE;
            env_out <= '0;
            counter <= '0;
          end
        endcase
      end
    end
  end

  // The strobe and active flag come only from registers. The strobe is high
  // for the single cycle in which env_out differs from its previous value.
  assign env_strobe = (env_out != env_prev);
  assign active     = (st != IDLE);
  assign state      = st;

endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env
// Directed testbench for adsr_env. A cycle-level reference model runs on each
// rising edge and pushes the expected outputs into a scoreboard queue. Each
// falling edge pops that entry and compares it against the DUT. Milestone
// checks against fixed levels and states mark the key points of each scenario.
module tb_adsr_env;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        gate;
  logic [31:0] attack_time;
  logic [31:0] decay_time;
  logic [6:0]  sustain_level;
  logic [31:0] release_time;
  logic [6:0]  env_out;
  logic        env_strobe;
  logic [2:0]  state;
  logic        active;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int st;
    int env;
    bit strobe;
    bit act;
  } exp_t;

  exp_t sbq[$];

  // Reference model state
  int     mSt      = 0;
  int     mEnv     = 0;
  int     mEnvPrev = 0;
  longint mCnt     = 0;
  bit     mGateD   = 1'b0;

  int tickPeriod = 1;
  int tickPhase  = 0;
  bit lastTick   = 1'b0;
  int e0;
  int e1;

  adsr_env #(.TIME_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .gate          (gate),
    .attack_time   (attack_time),
    .decay_time    (decay_time),
    .sustain_level (sustain_level),
    .release_time  (release_time),
    .env_out       (env_out),
    .env_strobe    (env_strobe),
    .state         (state),
    .active        (active)
  );

  // Free-running clock with a 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends, even if the bench itself goes wrong
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison, counted and reported on failure
  task automatic checkValue(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Step period of the model's current phase, with zero treated as one
  function automatic longint periodFor(input int s);
    longint p;
    case (s)
      1:       p = longint'(attack_time);
      2:       p = longint'(decay_time);
      4:       p = longint'(release_time);
      default: p = 1;
    endcase
    return (p == 0) ? 1 : p;
  endfunction

  task automatic modelReset();
    mSt      = 0;
    mEnv     = 0;
    mEnvPrev = 0;
    mCnt     = 0;
    mGateD   = 1'b0;
  endtask

  // Advance the reference envelope by one rising edge using the current inputs
  task automatic modelUpdate();
    bit     rise;
    bit     fall;
    bit     stp;
    longint per;
    if (!rst_n) begin
      modelReset();
      return;
    end
    mEnvPrev = mEnv;
    rise     = gate && !mGateD;
    fall     = !gate && mGateD;
    mGateD   = gate;
    per      = periodFor(mSt);
    stp      = tick && (mCnt + 1 >= per);
    if (rise) begin
      mSt  = 1;
      mCnt = 0;
    end else if (fall && mSt >= 1 && mSt <= 3) begin
      mSt  = 4;
      mCnt = 0;
    end else begin
      case (mSt)
        1: begin
          if (mEnv == 127) begin
            mSt = 2; mCnt = 0;
          end else if (stp) begin
            mEnv++; mCnt = 0;
            if (mEnv == 127) mSt = 2;
          end else if (tick) mCnt++;
        end
        2: begin
          if (mEnv <= int'(sustain_level)) begin
            mSt = 3; mEnv = int'(sustain_level); mCnt = 0;
          end else if (stp) begin
            mEnv--; mCnt = 0;
            if (mEnv <= int'(sustain_level)) mSt = 3;
          end else if (tick) mCnt++;
        end
        3: begin
          mEnv = int'(sustain_level);
          mCnt = 0;
        end
        4: begin
          if (mEnv == 0) begin
            mSt = 0; mCnt = 0;
          end else if (stp) begin
            mEnv--; mCnt = 0;
            if (mEnv == 0) mSt = 0;
          end else if (tick) mCnt++;
        end
        default: begin
          mEnv = 0;
          mCnt = 0;
        end
      endcase
    end
  endtask

  // Pop the oldest expected entry and compare every output against it
  task automatic checkOutput();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sbq.pop_front();
      checkValue("sb_env", int'(env_out), e.env);
      checkValue("sb_state", int'(state), e.st);
      checkValue("sb_strobe", int'(env_strobe), int'(e.strobe));
      checkValue("sb_active", int'(active), int'(e.act));
    end
  endtask

  // Run n clock cycles. Tick is driven from the phase counter, the model
  // advances at the rising edge and the DUT is checked at the falling edge.
  task automatic applyStimulus(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      tick     = ((tickPhase % tickPeriod) == 0);
      lastTick = tick;
      tickPhase++;
      @(posedge clk);
      modelUpdate();
      e.st     = mSt;
      e.env    = mEnv;
      e.strobe = (mEnv != mEnvPrev);
      e.act    = (mSt != 0);
      sbq.push_back(e);
      @(negedge clk);
      checkOutput();
    end
  endtask

  initial begin
    rst_n         = 1'b1;
    tick          = 1'b0;
    gate          = 1'b0;
    attack_time   = 32'd4;
    decay_time    = 32'd2;
    sustain_level = 7'd100;
    release_time  = 32'd0;
    #1 rst_n = 1'b0;
    #1;
    // Reset values before any clock edge
    checkValue("reset_env", int'(env_out), 0);
    checkValue("reset_state", int'(state), 0);
    checkValue("reset_strobe", int'(env_strobe), 0);
    checkValue("reset_active", int'(active), 0);
    modelReset();

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2);

    // Full attack/decay with tick held high
    gate = 1'b1;
    applyStimulus(1);
    checkValue("rise_state", int'(state), 1);
    checkValue("rise_env", int'(env_out), 0);
    applyStimulus(508);
    checkValue("attack_peak_env", int'(env_out), 127);
    checkValue("attack_peak_state", int'(state), 2);
    applyStimulus(54);
    checkValue("decay_end_env", int'(env_out), 100);
    checkValue("decay_end_state", int'(state), 3);

    // Release with a zero period: one step per tick
    gate = 1'b0;
    applyStimulus(1);
    checkValue("release_state", int'(state), 4);
    applyStimulus(99);
    checkValue("release_last_env", int'(env_out), 1);
    checkValue("release_last_active", int'(active), 1);
    applyStimulus(1);
    checkValue("release_done_env", int'(env_out), 0);
    checkValue("release_done_state", int'(state), 0);
    checkValue("release_done_active", int'(active), 0);

    // Retrigger from the middle of a release
    attack_time = 32'd1;
    decay_time  = 32'd1;
    gate        = 1'b1;
    applyStimulus(155);
    checkValue("fast_sustain_env", int'(env_out), 100);
    checkValue("fast_sustain_state", int'(state), 3);
    release_time = 32'd2;
    gate         = 1'b0;
    applyStimulus(81);
    checkValue("release60_env", int'(env_out), 60);
    checkValue("release60_state", int'(state), 4);
    attack_time = 32'd4;
    gate        = 1'b1;
    applyStimulus(1);
    checkValue("retrig_state", int'(state), 1);
    checkValue("retrig_env", int'(env_out), 60);
    applyStimulus(4);
    checkValue("retrig_step_env", int'(env_out), 61);

    // Sustain at full scale: no downward steps
    sustain_level = 7'd127;
    attack_time   = 32'd1;
    applyStimulus(66);
    checkValue("sus127_peak_env", int'(env_out), 127);
    applyStimulus(1);
    checkValue("sus127_state", int'(state), 3);
    applyStimulus(10);
    checkValue("sus127_hold_env", int'(env_out), 127);
    checkValue("sus127_no_strobe", int'(env_strobe), 0);

    // Live sustain tracking produces a strobe
    sustain_level = 7'd90;
    applyStimulus(1);
    checkValue("track_env", int'(env_out), 90);
    checkValue("track_strobe", int'(env_strobe), 1);
    applyStimulus(1);
    checkValue("track_strobe_end", int'(env_strobe), 0);
    release_time = 32'd0;
    gate         = 1'b0;
    applyStimulus(91);
    checkValue("idle_again_state", int'(state), 0);

    // Tick every third cycle with attack_time=2: one step per 6 clocks
    tickPeriod  = 3;
    tickPhase   = 0;
    attack_time = 32'd2;
    gate        = 1'b1;
    applyStimulus(6);
    e0 = int'(env_out);
    applyStimulus(12);
    checkValue("tick3_rate", int'(env_out), e0 + 2);

    // Shortening a long period mid-count steps on the very next tick
    attack_time = 32'd1000;
    applyStimulus(7);
    e1 = int'(env_out);
    attack_time = 32'd1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      if (lastTick) break;
    end
    checkValue("period_cut_step", int'(env_out), e1 + 1);

    // Asynchronous reset in the middle of an attack at level 40
    tickPeriod   = 1;
    release_time = 32'd0;
    gate         = 1'b0;
    applyStimulus(20);
    checkValue("pre_reset_idle", int'(state), 0);
    gate = 1'b1;
    applyStimulus(41);
    checkValue("pre_reset_env", int'(env_out), 40);
    checkValue("pre_reset_state", int'(state), 1);
    #2 rst_n = 1'b0;
    #1;
    checkValue("async_env", int'(env_out), 0);
    checkValue("async_state", int'(state), 0);
    checkValue("async_active", int'(active), 0);
    checkValue("async_strobe", int'(env_strobe), 0);
    modelReset();
    applyStimulus(2);

    // Reset released with the gate already high counts as a rise
    rst_n = 1'b1;
    applyStimulus(1);
    checkValue("rst_rise_state", int'(state), 1);
    checkValue("rst_rise_env", int'(env_out), 0);
    applyStimulus(3);
    checkValue("rst_rise_steps", int'(env_out), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adsr_env.md
ADSR_ENV -- requirements
Module: adsr_env

Interface
REQ-001 Parameter: TIME_W, 32, width of the step-period inputs (matches the lin2exp table output width).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick  input  1  one-cycle envelope-rate strobe; the period counter advances only when tick=1.
REQ-005 gate  input  1  note on (1) / note off (0), level-sensitive.
REQ-006 attack_time  input  TIME_W  ticks per +1 level step in ATTACK.
REQ-007 decay_time  input  TIME_W  ticks per -1 level step in DECAY.
REQ-008 sustain_level  input  7  sustain target level, 0..127.
REQ-009 release_time  input  TIME_W  ticks per -1 level step in RELEASE.
REQ-010 env_out  output  7  current envelope level, registered.
REQ-011 env_strobe  output  1  one-cycle pulse in the cycle after env_out changes value.
REQ-012 state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-013 active  output  1  high when state != IDLE.

Function
REQ-014 Registers gate_d <= gate every clk; rise = gate & ~gate_d, fall = ~gate & gate_d.
REQ-015 Rise in any state: state <= ATTACK, counter <= 0, env_out unchanged (retrigger from current level); visible the cycle after gate is first sampled high.
REQ-016 Fall in ATTACK, DECAY or SUSTAIN: state <= RELEASE, counter <= 0; fall in IDLE or RELEASE: no effect.
REQ-017 Gate events take priority over level steps in the same cycle; no step occurs in that cycle.
REQ-018 Effective period P = selected time input, with 0 treated as 1.
REQ-019 Step event: tick=1 and counter >= P-1; counter <= 0 on step, counter+1 on tick otherwise, hold when tick=0; compare is >= so a period reduced mid-phase cannot lock up.
REQ-020 ATTACK: step adds 1 to env_out; when env_out reaches 127 (by step or already at 127 on entry) state <= DECAY, counter <= 0.
REQ-021 DECAY: if env_out <= sustain_level, state <= SUSTAIN, env_out <= sustain_level; otherwise step subtracts 1.
REQ-022 SUSTAIN: env_out <= sustain_level every cycle (tracks live changes); counter held at 0.
REQ-023 RELEASE: step subtracts 1; when env_out = 0, state <= IDLE; a release entered at level 0 goes to IDLE next cycle.
REQ-024 IDLE: env_out held at 0, counter held at 0.
REQ-025 env_out never wraps: saturates at 0 and 127.
REQ-026 env_strobe asserts for exactly one cycle per env_out change, including sustain_level tracking changes.
REQ-027 Counter width TIME_W; time inputs may change at any time and take effect at the next compare.

Reset
REQ-028 rst_n=0 asynchronously forces state=IDLE, env_out=0, env_strobe=0, active=0, counter=0, gate_d=0.
REQ-029 Reset released with gate=1: treated as a rise on the first clk edge (gate_d=0), entering ATTACK.
REQ-030 Reset asserted mid-envelope aborts immediately, with no release phase.

Verification
REQ-031 tick=1 constantly, attack_time=4, decay_time=2, sustain_level=100, gate 0->1 -> env_out +1 every 4 cycles, 127 reached after 508 ticks, then DECAY -1 every 2 cycles, SUSTAIN at 100 after 54 further ticks.
REQ-032 In SUSTAIN at 100, gate 1->0 with release_time=0 -> RELEASE, -1 per tick, IDLE with env_out=0 after 100 ticks, active drops.
REQ-033 Gate 0->1 while in RELEASE at level 60 -> ATTACK starting from 60, with no jump to 0.
REQ-034 sustain_level=127 -> ATTACK goes to DECAY then SUSTAIN with no downward steps; env_out stays 127.
REQ-035 tick pulsed every 3rd cycle, attack_time=2 -> one step per 6 clk; attack_time changed from 1000 to 1 mid-count -> step on the next tick.
REQ-036 rst_n asserted asynchronously mid-ATTACK at level 40 -> env_out=0 and state=IDLE without waiting for a clk edge.
